iomem_initiator: RTL and testbench
==================================

# iomem_initiator

Bus-master for the SoC peripheral bus (iomem): accepts single read/write commands on a valid/ready command port, drives one iomem transaction at a time toward the peripheral decode logic, and returns the read data or write completion on a response port. It is the initiator end of the same iomem handshake the peripheral responders implement. It is used as a hardware bridge (debug/DMA front-end) and as the bus driver in peripheral benches. An optional watchdog terminates transactions no responder claims.

## Interface
- TIMEOUT_CYCLES, 255: max cycles iomem_valid may stay high without iomem_ready (watchdog build only); legal 2..65535.
- clk  in  1  system clock; single clock domain.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  32  byte address; bits [1:0] forced to 0 on iomem_addr.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte enables; 4'b0000 = read.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  transaction timed out.
- busy  out  1  high in any state except IDLE.
- iomem_valid  out  1  transaction request.
- iomem_ready  in  1  responder completion pulse.
- iomem_addr  out  32  word-aligned address.
- iomem_wdata  out  32  write data.
- iomem_wstrb  out  4  byte enables.
- iomem_rdata  in  32  read data, valid in the iomem_ready cycle.

## Operation
- States: IDLE, REQ, RSP. Reset state IDLE.
- Reset values: cmd_ready 0 during reset (1 in IDLE after release), rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, iomem_valid 0, iomem_addr/wdata/wstrb 0.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: register addr (with [1:0]=0), wdata, wstrb onto iomem_* and go REQ.
- REQ: iomem_valid=1; iomem_addr/wdata/wstrb held stable. On iomem_ready=1: capture iomem_rdata if wstrb==0 else 0, rsp_err=0, go RSP; iomem_valid deasserts on that same edge (mandatory: responders re-trigger on valid&&!ready).
- RSP: rsp_valid=1, rsp_rdata/rsp_err stable. On rsp_ready=1 go IDLE; rsp_valid drops next cycle.
- iomem_ready outside REQ is ignored; rdata not captured.
- cmd_valid while not IDLE is not accepted (cmd_ready=0); no queueing.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously; in-flight transaction abandoned, no response.

## Timing
- Accept at edge E0 -> iomem_valid high after E0.
- Responder registering ready one cycle after valid: ready seen at E2 -> rsp_valid high after E2 (2 cycles accept-to-response).
- rsp_ready high in the first RSP cycle -> IDLE after the next edge; back-to-back command accepted at the following edge; min 4 cycles per transaction.
- iomem_valid is never high in the cycle after a sampled iomem_ready.

## Configuration
- IOMEM_INIT_TIMEOUT_EN defined: 16-bit counter cleared on REQ entry, incremented each REQ cycle without iomem_ready; when it equals TIMEOUT_CYCLES-1 with iomem_ready low, drop iomem_valid, go RSP with rsp_err=1, rsp_rdata=0. iomem_ready in the expiry cycle wins (normal completion, rsp_err=0).
- Not defined: no counter; REQ waits indefinitely; rsp_err tied 0; TIMEOUT_CYCLES unused.

## Test plan
- Read: cmd_addr=32'h0300_0003, wstrb=0; responder returns 32'hA5A5_1234 one cycle after valid -> iomem_addr=32'h0300_0000, rsp_valid 2 cycles after accept, rsp_rdata=32'hA5A5_1234, rsp_err=0.
- Write: addr 32'h0300_0200, wdata 32'h0000_00FF, wstrb 4'b0001 -> iomem_wstrb=4'b0001 held until ready, rsp_rdata=0, iomem_valid low the cycle after ready.
- Backpressure: rsp_ready low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, second command accepted only after rsp_ready.
- Timeout (macro on, TIMEOUT_CYCLES=8): address 32'h0500_0000 never answered -> iomem_valid high exactly 8 cycles, rsp_err=1, rsp_rdata=0; ready on cycle 8 instead -> rsp_err=0.
- Reset mid-REQ: resetn low with iomem_valid=1 -> iomem_valid, busy, rsp_valid 0 before next clk edge; after release, cmd_ready=1 and a fresh read completes normally.

Source files
------------

// File: rtl/iomem_initiator.sv
// iomem bus master: takes one command at a time, runs a single iomem transaction, and returns the result.
// Define IOMEM_INIT_TIMEOUT_EN to add a watchdog that ends transactions no responder claims.
module iomem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  output logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are
  // both high; valid stays up and its payload stays stable until that edge.
  // iomem_ready is a one-cycle completion pulse, only meaningful while in REQ.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("iomem_initiator: TIMEOUT_CYCLES must be within 2..65535");
  end

  state_e      state_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        busy_q;
  logic        iomem_valid_q;
  logic [31:0] iomem_addr_q;
  logic [31:0] iomem_wdata_q;
  logic [3:0]  iomem_wstrb_q;

`ifdef IOMEM_INIT_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      iomem_valid_q <= 1'b0;
      iomem_addr_q  <= 32'h0;
      iomem_wdata_q <= 32'h0;
      iomem_wstrb_q <= 4'h0;
`ifdef IOMEM_INIT_TIMEOUT_EN
      wdog_q        <= 16'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // cmd_ready rises one cycle after reset release, then stays up in IDLE.
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            iomem_addr_q  <= cmd_addr & 32'hFFFF_FFFC;
            iomem_wdata_q <= cmd_wdata;
            iomem_wstrb_q <= cmd_wstrb;
            iomem_valid_q <= 1'b1;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= REQ;
`ifdef IOMEM_INIT_TIMEOUT_EN
            wdog_q        <= 16'h0;
`endif
          end
        end
        REQ: begin
          if (iomem_ready) begin
            // valid must fall on this edge so the responder does not see a new request.
            rsp_rdata_q   <= (iomem_wstrb_q == 4'h0) ? iomem_rdata : 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            iomem_valid_q <= 1'b0;
            state_q       <= RSP;
          end
`ifdef IOMEM_INIT_TIMEOUT_EN
          else if (wdog_q == TO_LAST) begin
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b1;
            rsp_valid_q   <= 1'b1;
            iomem_valid_q <= 1'b0;
            state_q       <= RSP;
          end else begin
            wdog_q <= wdog_q + 16'd1;
          end
`endif
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q       <= IDLE;
          cmd_ready_q   <= 1'b0;
          rsp_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
          iomem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign iomem_valid = iomem_valid_q;
  assign iomem_addr  = iomem_addr_q;
  assign iomem_wdata = iomem_wdata_q;
  assign iomem_wstrb = iomem_wstrb_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator: read, write, backpressure, watchdog and mid-transaction reset.
module tb_iomem_initiator;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_rdata;
  logic [1:0]  dbg_state;

  int tests_run;
  int tests_failed;

  iomem_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang exp finish");
    $fatal(1, "bench timeout");
  end

  // driver tasks: step one cycle and land #1 past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; iomem_ready = 1'b0; iomem_rdata = '0;
    #3;
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b exp 0", cmd_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests_run++; if (iomem_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_iomem_valid: got %b exp 0", iomem_valid); end
    tests_run++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_rsp: got v=%b e=%b d=%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); end
    tests_run++; if (iomem_addr !== 32'h0 || iomem_wdata !== 32'h0 || iomem_wstrb !== 4'h0) begin
      tests_failed++; $display("FAIL reset_iomem_bus: got a=%h d=%h s=%h exp 0", iomem_addr, iomem_wdata, iomem_wstrb); end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    tests_run++; if (cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin
      tests_failed++; $display("FAIL post_reset_idle: got rdy=%b st=%0d exp 1/0", cmd_ready, dbg_state); end
  endtask

  task automatic test_read();
    offer_cmd(32'h0300_0003, 32'h0, 4'b0000);
    tick();                                   // E0: accept
    cmd_valid = 1'b0;
    tests_run++; if (iomem_valid !== 1'b1 || iomem_addr !== 32'h0300_0000) begin
      tests_failed++; $display("FAIL read_req: got v=%b a=%h exp 1/03000000", iomem_valid, iomem_addr); end
    tests_run++; if (cmd_ready !== 1'b0 || busy !== 1'b1 || dbg_state !== 2'd1) begin
      tests_failed++; $display("FAIL read_busy: got rdy=%b busy=%b st=%0d exp 0/1/1", cmd_ready, busy, dbg_state); end
    tick();                                   // E1: responder registers ready
    iomem_ready = 1'b1; iomem_rdata = 32'hA5A5_1234;
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL read_early_rsp: got %b exp 0", rsp_valid); end
    tick();                                   // E2: ready sampled
    iomem_ready = 1'b0; iomem_rdata = 32'h5555_AAAA;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_1234 || rsp_err !== 1'b0) begin
      tests_failed++; $display("FAIL read_rsp: got v=%b d=%h e=%b exp 1/a5a51234/0", rsp_valid, rsp_rdata, rsp_err); end
    tests_run++; if (iomem_valid !== 1'b0) begin tests_failed++; $display("FAIL read_valid_drop: got %b exp 0", iomem_valid); end
    finish_rsp();
    tests_run++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL read_done: got v=%b rdy=%b busy=%b exp 0/1/0", rsp_valid, cmd_ready, busy); end
  endtask

  task automatic test_write();
    offer_cmd(32'h0300_0200, 32'h0000_00FF, 4'b0001);
    tick();
    cmd_valid = 1'b0; cmd_wstrb = 4'h0; cmd_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (iomem_valid !== 1'b1 || iomem_wstrb !== 4'b0001 || iomem_wdata !== 32'hFF ||
                       iomem_addr !== 32'h0300_0200) begin
        tests_failed++; $display("FAIL write_hold[%0d]: got v=%b s=%b d=%h a=%h exp 1/0001/ff/03000200",
                                 i, iomem_valid, iomem_wstrb, iomem_wdata, iomem_addr); end
      tick();
    end
    iomem_ready = 1'b1; iomem_rdata = 32'hDEAD_BEEF;
    tick();
    tests_run++; if (iomem_valid !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL write_rsp: got v=%b rv=%b d=%h exp 0/1/0", iomem_valid, rsp_valid, rsp_rdata); end
    iomem_rdata = 32'h1357_9BDF;               // stray ready outside REQ must be ignored
    tick();
    iomem_ready = 1'b0;
    tests_run++; if (rsp_rdata !== 32'h0 || iomem_valid !== 1'b0 || rsp_valid !== 1'b1) begin
      tests_failed++; $display("FAIL write_stray_ready: got d=%h v=%b rv=%b exp 0/0/1", rsp_rdata, iomem_valid, rsp_valid); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    offer_cmd(32'h0300_0004, 32'h0, 4'b0000);
    tick();
    offer_cmd(32'h0300_0010, 32'h0, 4'b0000); // second command offered while busy
    tick();
    iomem_ready = 1'b1; iomem_rdata = 32'h1122_3344;
    tick();
    iomem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_3344 || cmd_ready !== 1'b0 || iomem_valid !== 1'b0) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: got rv=%b d=%h rdy=%b iv=%b exp 1/11223344/0/0",
                                 i, rsp_valid, rsp_rdata, cmd_ready, iomem_valid); end
      tick();
    end
    finish_rsp();
    tests_run++; if (cmd_ready !== 1'b1 || iomem_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_release: got rdy=%b iv=%b exp 1/0", cmd_ready, iomem_valid); end
    tick();                                   // second command accepted here
    cmd_valid = 1'b0;
    tests_run++; if (iomem_valid !== 1'b1 || iomem_addr !== 32'h0300_0010) begin
      tests_failed++; $display("FAIL bp_second: got v=%b a=%h exp 1/03000010", iomem_valid, iomem_addr); end
    iomem_ready = 1'b1; iomem_rdata = 32'h0000_0042;
    tick();
    iomem_ready = 1'b0;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0042) begin
      tests_failed++; $display("FAIL bp_second_rsp: got v=%b d=%h exp 1/00000042", rsp_valid, rsp_rdata); end
    finish_rsp();
  endtask

  task automatic test_timeout();
    int n;
    offer_cmd(32'h0500_0000, 32'h0, 4'b0000);
    tick();
    cmd_valid = 1'b0;
`ifdef IOMEM_INIT_TIMEOUT_EN
    n = 0;
    while (iomem_valid === 1'b1 && n < 20) begin n++; tick(); end
    tests_run++; if (n != 8) begin tests_failed++; $display("FAIL to_valid_cycles: got %0d exp 8", n); end
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL to_rsp: got v=%b e=%b d=%h exp 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    finish_rsp();
    offer_cmd(32'h0500_0000, 32'h0, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    repeat (7) tick();                        // now in the 8th REQ cycle
    iomem_ready = 1'b1; iomem_rdata = 32'h0BAD_F00D;
    tick();
    iomem_ready = 1'b0;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      tests_failed++; $display("FAIL to_last_cycle_ready: got v=%b e=%b d=%h exp 1/0/0badf00d", rsp_valid, rsp_err, rsp_rdata); end
    finish_rsp();
`else
    n = 0;
    repeat (20) begin if (iomem_valid === 1'b1 && rsp_valid === 1'b0) n++; tick(); end
    tests_run++; if (n != 20) begin tests_failed++; $display("FAIL no_wdog_wait: got %0d exp 20", n); end
    iomem_ready = 1'b1; iomem_rdata = 32'h0BAD_F00D;
    tick();
    iomem_ready = 1'b0;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      tests_failed++; $display("FAIL no_wdog_rsp: got v=%b e=%b d=%h exp 1/0/0badf00d", rsp_valid, rsp_err, rsp_rdata); end
    finish_rsp();
`endif
  endtask

  task automatic test_reset_mid();
    offer_cmd(32'h0300_0020, 32'h0, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    tests_run++; if (iomem_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_req: got %b exp 1", iomem_valid); end
    #2 resetn = 1'b0;
    #1;
    tests_run++; if (iomem_valid !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      tests_failed++; $display("FAIL mid_async_reset: got iv=%b busy=%b rv=%b rdy=%b exp 0/0/0/0",
                               iomem_valid, busy, rsp_valid, cmd_ready); end
    iomem_ready = 1'b1; iomem_rdata = 32'hFFFF_FFFF; // late ready must not produce a response
    tick();
    iomem_ready = 1'b0;
    resetn = 1'b1;
    tick();
    tests_run++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_after_release: got rdy=%b rv=%b exp 1/0", cmd_ready, rsp_valid); end
    offer_cmd(32'h0300_0033, 32'h0, 4'b0000);
    tick();
    cmd_valid = 1'b0;
    tick();
    iomem_ready = 1'b1; iomem_rdata = 32'hCAFE_0001;
    tick();
    iomem_ready = 1'b0;
    tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001 || iomem_addr !== 32'h0300_0030) begin
      tests_failed++; $display("FAIL mid_fresh_read: got v=%b d=%h a=%h exp 1/cafe0001/03000030", rsp_valid, rsp_rdata, iomem_addr); end
    finish_rsp();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
